// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply/divide sequencer: radix-2 Booth multiply and restoring
// divide over WIDTH iterations, sharing one (WIDTH+2)-bit adder/subtractor.
module multdiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH);

    logic [1:0]              state;
    logic [CNT_W-1:0]        counter;
    // Booth upper half is one bit wider so subtracting -2^(WIDTH-1) cannot overflow.
    logic signed [WIDTH:0]   acc;
    logic [WIDTH-1:0]        lo;
    logic                    qm1;
    logic signed [WIDTH:0]   opnd;
    logic                    q_neg;

    logic signed [WIDTH+1:0] add_a;
    logic signed [WIDTH+1:0] add_b;
    logic signed [WIDTH+1:0] add_sum;
    logic                    add_sub;

    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        return v[WIDTH-1] ? -ext : ext;
    endfunction

    function automatic logic mult_overflow(input logic [WIDTH:0] hi_bits);
        return !((&hi_bits) || (~|hi_bits));
    endfunction

    function automatic logic [WIDTH-1:0] div_quotient(input logic [WIDTH-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        if (state == S_DIV) begin
            // Partial remainder shifted left with the next dividend bit, minus |divisor|.
            add_a   = {1'b0, acc[WIDTH-1:0], lo[WIDTH-1]};
            add_b   = {1'b0, opnd};
            add_sub = 1'b1;
        end else begin
            add_a   = {acc[WIDTH], acc};
            add_b   = (lo[0] != qm1) ? {opnd[WIDTH], opnd} : '0;
            add_sub = lo[0] & ~qm1;
        end
        add_sum = add_sub ? (add_a - add_b) : (add_a + add_b);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            counter        <= '0;
            acc            <= '0;
            lo             <= '0;
            qm1            <= 1'b0;
            opnd           <= '0;
            q_neg          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT || ctrl_DIV) begin
                counter <= '0;
                acc     <= '0;
                qm1     <= 1'b0;
                if (ctrl_MULT) begin
                    state <= S_MULT;
                    lo    <= data_operandB;
                    opnd  <= {data_operandA[WIDTH-1], data_operandA};
                    q_neg <= 1'b0;
                end else begin
                    state <= S_DIV;
                    lo    <= WIDTH'(magnitude(data_operandA));
                    opnd  <= magnitude(data_operandB);
                    q_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                end
            end else begin
                case (state)
                    S_MULT: begin
                        if (counter == LAST_ITER) begin
                            state          <= S_DONE;
                            data_resultRDY <= 1'b1;
                            data_result    <= lo;
                            data_exception <= mult_overflow({acc[WIDTH-1:0], lo[WIDTH-1]});
                        end else begin
                            acc     <= {add_sum[WIDTH], add_sum[WIDTH:1]};
                            lo      <= {add_sum[0], lo[WIDTH-1:1]};
                            qm1     <= lo[0];
                            counter <= counter + CNT_W'(1);
                        end
                    end
                    S_DIV: begin
                        if (counter == LAST_ITER) begin
                            state          <= S_DONE;
                            data_resultRDY <= 1'b1;
                            // Only |A|=2^(WIDTH-1), B=-1 yields an unrepresentable positive quotient.
                            if (opnd == '0) begin
                                data_result    <= '0;
                                data_exception <= 1'b1;
                            end else begin
                                data_result    <= div_quotient(lo, q_neg);
                                data_exception <= ~q_neg & lo[WIDTH-1];
                            end
                        end else begin
                            if (add_sum[WIDTH+1]) begin
                                acc <= {acc[WIDTH-1:0], lo[WIDTH-1]};
                            end else begin
                                acc <= add_sum[WIDTH:0];
                            end
                            lo      <= {lo[WIDTH-2:0], ~add_sum[WIDTH+1]};
                            counter <= counter + CNT_W'(1);
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Iterative signed multiply/divide unit that runs beside the ALU in the execute stage.
- Sequences a radix-2 Booth multiplier and a shift-subtract divider over WIDTH iterations using one shared adder/subtractor.
- Reports completion with a one-cycle ready pulse, which the processor uses to stall and then write back.

Parameters:
- WIDTH, 32, operand and result width in bits; iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- data_operandA  input  WIDTH  multiplicand / dividend (two's complement).
- data_operandB  input  WIDTH  multiplier / divisor (two's complement).
- ctrl_MULT  input  1  start-multiply pulse, sampled on the clock edge.
- ctrl_DIV  input  1  start-divide pulse, sampled on the clock edge.
- data_result  output  WIDTH  low WIDTH bits of the product, or the quotient.
- data_exception  output  1  overflow or divide-by-zero flag, valid with data_result.
- data_resultRDY  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, counter=0, all datapath registers=0.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - An operation in flight is discarded; no ready pulse is produced.
- States: IDLE, MULT, DIV, DONE.
- Start:
  - On an edge with ctrl_MULT=1 (from any state), latch A and B, clear counter, go to MULT.
  - Else on an edge with ctrl_DIV=1, do the same and go to DIV.
  - If both are high, MULT wins.
  - A start while in MULT/DIV aborts the current operation and restarts with the new operands; no ready pulse for the aborted op.
- MULT:
  - Booth radix-2 on a 2*WIDTH+1 register {upper, lower=B, q(-1)=0}.
  - Each edge: add A, subtract A or do nothing per {q0,q(-1)}, then arithmetic-shift right by 1.
  - WIDTH iterations (counter 0..WIDTH-1), then DONE.
- DIV:
  - Operate on magnitudes |A|, |B| (the |-2^(WIDTH-1)| magnitude is held in WIDTH+1 bits).
  - Restoring shift-subtract: one quotient bit per edge.
  - WIDTH iterations, then DONE.
  - Quotient sign = sign(A) XOR sign(B); truncate toward zero; remainder discarded.
- Latency:
  - Start edge = cycle 0.
  - Iteration edges 1..WIDTH.
  - Edge WIDTH+1 enters DONE.
  - data_resultRDY is high for exactly the cycle following edge WIDTH+1, i.e. 33 cycles after the start edge for WIDTH=32.
  - Divide-by-zero takes the same full latency.
- DONE:
  - Assert data_resultRDY for one cycle.
  - Next edge goes to IDLE unless a new start is present, in which case it goes directly to MULT/DIV.
- Output hold:
  - data_result and data_exception update only on the DONE-entry edge.
  - They hold stable through IDLE until the next completion.
  - Outputs are not cleared by a start.
- Exceptions:
  - MULT: data_exception=1 when the 2*WIDTH-bit signed product does not fit in WIDTH bits (upper WIDTH+1 bits not all equal). data_result is still the low WIDTH bits.
  - DIV by B=0: data_result=0, data_exception=1.
  - DIV of -2^(WIDTH-1) by -1: data_result=0x80000000, data_exception=1.
  - All other divides: data_exception=0.
- Inputs are ignored except on start edges; operands may change freely during an operation.

Test Plan:
- Reset, then ctrl_MULT with A=7, B=-6 -> exactly 33 cycles later data_resultRDY=1 for one cycle, data_result=0xFFFFFFD6 (-42), data_exception=0; result holds afterwards.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1; then A=0x7FFFFFFF, B=1 -> data_result=0x7FFFFFFF, data_exception=0.
- ctrl_DIV with A=-17, B=5 -> data_result=0xFFFFFFFD (-3), data_exception=0; then A=17, B=0 -> data_result=0, data_exception=1 after the full 33 cycles.
- ctrl_DIV with A=0x80000000, B=-1 -> data_result=0x80000000, data_exception=1; then A=0x80000000, B=2 -> data_result=0xC0000000, data_exception=0.
- Start ctrl_DIV (100/7), assert ctrl_MULT with A=3, B=4 on cycle 10 -> no ready pulse for the divide; ready 33 cycles after cycle 10 with data_result=12. Simultaneous ctrl_MULT and ctrl_DIV with A=6, B=3 -> data_result=18.
- Assert reset asynchronously mid-multiply (cycle 15, off clock edge) -> all outputs 0 immediately; no ready pulse. After release, a new ctrl_MULT with A=-1, B=-1 -> data_result=1 at 33 cycles.
